// File: rtl/addsub_arbiter_pkg.sv
// Shared constants and types for the two-requester add/subtract arbiter.
package addsub_arbiter_pkg;

    // Datapath width.
    localparam int DW = 8;

    // Operation mode encoding on reqN_m.
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Arbiter FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Operand register contents captured on the grant edge.
    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          m;
        logic          id;
    } op_t;

    // Round-robin pick: a lone requester wins; under contention the
    // requester that was not served last wins.
    function automatic logic pick_grant(input logic v0, input logic v1, input logic last);
        logic id;
        if (v0 && v1) begin
            id = ~last;
        end else begin
            id = v1;
        end
        return id;
    endfunction

endpackage

// File: rtl/addsub_arbiter_dp.sv
// Combinational 8-bit two's-complement add/subtract with signed overflow.
// Subtract is a + ~b + 1: the mode bit doubles as the carry-in.
module addsub_arbiter_dp
    import addsub_arbiter_pkg::*;
(
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic          m_i,
    output logic [DW-1:0] w_o,
    output logic          ov_o
);

    logic [DW-1:0] b_x;
    logic [DW-2:0] low;
    logic          c6;
    logic          c7;
    logic          msb;

    // Split the add at the sign bit so both carries needed for overflow are visible.
    always_comb begin
        b_x        = (m_i == MODE_SUB) ? ~b_i : b_i;
        {c6, low}  = {1'b0, a_i[DW-2:0]} + {1'b0, b_x[DW-2:0]} + {{(DW-1){1'b0}}, m_i};
        {c7, msb}  = {1'b0, a_i[DW-1]} + {1'b0, b_x[DW-1]} + {1'b0, c6};
        w_o        = {msb, low};
        ov_o       = c7 ^ c6;
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/subtract datapath between two
// requesters, one operation in flight, with a saturating overflow counter.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The arbiter asserts reqN_ready only in IDLE for the requester it
// grants, combinationally from reqN_valid; requesters may drop valid before
// being granted. rspN_valid stays high, with rsp_w/rsp_ov stable, until the
// requester answers with rspN_ready; ready on the other port is ignored.
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [DW-1:0]        req0_a,
    input  logic [DW-1:0]        req0_b,
    input  logic                 req0_m,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [DW-1:0]        req1_a,
    input  logic [DW-1:0]        req1_b,
    input  logic                 req1_m,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [DW-1:0]        rsp_w,
    output logic                 rsp_ov,
    output logic                 busy,
    input  logic                 ovf_clr,
    output logic [OVF_CNT_W-1:0] ovf_count,
    output logic [1:0]           dbg_state
);

    localparam logic [OVF_CNT_W-1:0] CNT_ONE = {{(OVF_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [OVF_CNT_W-1:0] CNT_MAX = {OVF_CNT_W{1'b1}};

    state_e                 state_q, state_d;
    op_t                    op_q, op_d;
    logic                   last_grant_q, last_grant_d;
    logic [DW-1:0]          rsp_w_q, rsp_w_d;
    logic                   rsp_ov_q, rsp_ov_d;
    logic [OVF_CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;

    logic                   gnt_any;
    logic                   gnt_id;
    logic                   rsp_hs;
    logic [DW-1:0]          dp_w;
    logic                   dp_ov;

    // The single shared datapath always evaluates the latched operands.
    addsub_arbiter_dp u_dp (
        .a_i  (op_q.a),
        .b_i  (op_q.b),
        .m_i  (op_q.m),
        .w_o  (dp_w),
        .ov_o (dp_ov)
    );

    // Next-state, grant and response logic.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        last_grant_d = last_grant_q;
        rsp_w_d      = rsp_w_q;
        rsp_ov_d     = rsp_ov_q;
        ovf_cnt_d    = ovf_cnt_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        rsp_hs       = 1'b0;
        gnt_any      = req0_valid || req1_valid;
        gnt_id       = pick_grant(req0_valid, req1_valid, last_grant_q);

        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    op_d.id    = gnt_id;
                    op_d.a     = gnt_id ? req1_a : req0_a;
                    op_d.b     = gnt_id ? req1_b : req0_b;
                    op_d.m     = gnt_id ? req1_m : req0_m;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_w_d      = dp_w;
                rsp_ov_d     = dp_ov;
                last_grant_d = op_q.id;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                rsp0_valid = ~op_q.id;
                rsp1_valid = op_q.id;
                rsp_hs     = op_q.id ? rsp1_ready : rsp0_ready;
                if (rsp_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rsp_hs && rsp_ov_q && (ovf_cnt_q != CNT_MAX)) begin
            ovf_cnt_d = ovf_cnt_q + CNT_ONE;
        end
        if (ovf_clr) begin
            ovf_cnt_d = '0;
        end
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            last_grant_q <= 1'b1;
            rsp_w_q      <= '0;
            rsp_ov_q     <= 1'b0;
            ovf_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            last_grant_q <= last_grant_d;
            rsp_w_q      <= rsp_w_d;
            rsp_ov_q     <= rsp_ov_d;
            ovf_cnt_q    <= ovf_cnt_d;
        end
    end

    assign rsp_w     = rsp_w_q;
    assign rsp_ov    = rsp_ov_q;
    assign busy      = (state_q != ST_IDLE);
    assign ovf_count = ovf_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: scoreboard of expected results
// pushed at request acceptance and popped at response handshake.
module tb_addsub_arbiter;

    localparam int CW = 2;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req0_ready, req0_m;
    logic [7:0]    req0_a, req0_b;
    logic          req1_valid, req1_ready, req1_m;
    logic [7:0]    req1_a, req1_b;
    logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [7:0]    rsp_w;
    logic          rsp_ov, busy, ovf_clr;
    logic [CW-1:0] ovf_count;
    logic [1:0]    dbg_state;

    // entry: {id, ov, w}
    logic [9:0]    exp_q[$];
    logic [CW-1:0] exp_cnt;
    int            total;
    int            bad;

    addsub_arbiter #(.OVF_CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_m     (req0_m),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_m     (req1_m),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_w      (rsp_w),
        .rsp_ov     (rsp_ov),
        .busy       (busy),
        .ovf_clr    (ovf_clr),
        .ovf_count  (ovf_count),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: signed integer arithmetic with range check
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic m);
        int sa, sb, r;
        logic [8:0] res;
        sa = $signed(a);
        sb = $signed(b);
        r  = m ? (sa - sb) : (sa + sb);
        res[7:0] = r[7:0];
        res[8]   = (r > 127) || (r < -128);
        return res;
    endfunction

    function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] c, input logic ov);
        return (ov && c != CMAX) ? c + 1'b1 : c;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_m = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_m = 0;
        rsp0_ready = 0; rsp1_ready = 0; ovf_clr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.delete();
        exp_cnt = '0;
    endtask

    // driver: present a request until accepted; returns at negedge after accept edge
    task automatic send_req(input logic id, input logic [7:0] a, input logic [7:0] b,
                            input logic m, output bit ok);
        ok = 0;
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_m = m; end
        else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_m = m; end
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1;
                exp_q.push_back({id, model(a, b, m)});
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        if (id) begin req1_valid = 0; req1_a = 8'hA5; end
        else    begin req0_valid = 0; req0_a = 8'h5A; end
    endtask

    // driver: wait for the response, capture it, then complete the handshake
    task automatic wait_rsp(input logic id, input logic clr, output logic [7:0] w,
                            output logic ov, output int lat, output bit ok);
        ok = 0; lat = 1; w = 'x; ov = 'x;
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((id ? rsp1_valid : rsp0_valid) === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        w = rsp_w; ov = rsp_ov;
        if (id) rsp1_ready = 1; else rsp0_ready = 1;
        ovf_clr = clr;
        @(posedge clk);
        @(negedge clk);
        rsp0_ready = 0; rsp1_ready = 0; ovf_clr = 0;
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        do_reset();
        #1;
        obs = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_w, rsp_ov, busy};
        total++;
        if (obs !== 14'd0 || ovf_count !== '0 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_outputs: got outs=%h cnt=%0d st=%0d, want 0", obs, ovf_count, dbg_state);
        end
    endtask

    task automatic test_add();
        bit ok, rok; logic [7:0] w; logic ov; int lat; logic [9:0] e;
        send_req(0, 8'd100, 8'd27, 1'b0, ok);
        wait_rsp(0, 1'b0, w, ov, lat, rok);
        e = exp_q.pop_front();
        exp_cnt = cnt_step(exp_cnt, e[8]);
        total++;
        if (!ok || !rok || lat !== 2) begin
            bad++; $display("FAIL add_handshake: acc=%0d rsp=%0d lat=%0d, want 1 1 2", ok, rok, lat);
        end
        total++;
        if ({ov, w} !== e[8:0]) begin
            bad++; $display("FAIL add_result: got w=%h ov=%b, want w=%h ov=%b", w, ov, e[7:0], e[8]);
        end
        total++;
        if (ovf_count !== exp_cnt) begin
            bad++; $display("FAIL add_count: got %0d want %0d", ovf_count, exp_cnt);
        end
    endtask

    task automatic test_overflow();
        logic [16:0] tbl [2] = '{{8'd100, 8'd28, 1'b0}, {8'h80, 8'h01, 1'b1}};
        bit ok, rok; logic [7:0] w; logic ov; int lat; logic [9:0] e;
        for (int i = 0; i < 2; i++) begin
            send_req(0, tbl[i][16:9], tbl[i][8:1], tbl[i][0], ok);
            wait_rsp(0, 1'b0, w, ov, lat, rok);
            e = exp_q.pop_front();
            exp_cnt = cnt_step(exp_cnt, e[8]);
            total++;
            if (!ok || !rok || lat !== 2 || {ov, w} !== e[8:0]) begin
                bad++;
                $display("FAIL ovf_result[%0d]: got w=%h ov=%b lat=%0d, want w=%h ov=%b lat=2",
                         i, w, ov, lat, e[7:0], e[8]);
            end
            total++;
            if (ovf_count !== exp_cnt) begin
                bad++; $display("FAIL ovf_count[%0d]: got %0d want %0d", i, ovf_count, exp_cnt);
            end
        end
    endtask

    task automatic test_contention();
        int g_id[$], g_cyc[$];
        int both_rdy, both_rsp, n_rsp, bad_rsp;
        bit drop;
        logic [9:0] e;
        do_reset();
        both_rdy = 0; both_rsp = 0; n_rsp = 0; bad_rsp = 0; drop = 0;
        req0_a = 1; req0_b = 1; req0_m = 0;
        req1_a = 5; req1_b = 3; req1_m = 1;
        req0_valid = 1; req1_valid = 1;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (drop) begin req0_valid = 0; req1_valid = 0; drop = 0; end
            #1;
            if (req0_ready && req1_ready) both_rdy++;
            if (rsp0_valid && rsp1_valid) both_rsp++;
            if (rsp0_valid || rsp1_valid) begin
                n_rsp++;
                if (exp_q.size() == 0) bad_rsp++;
                else begin
                    e = exp_q.pop_front();
                    if (e !== {rsp1_valid, rsp_ov, rsp_w}) bad_rsp++;
                end
            end
            if (req0_ready || req1_ready) begin
                g_id.push_back(req1_ready ? 1 : 0);
                g_cyc.push_back(cyc);
                exp_q.push_back(req1_ready ? {1'b1, model(req1_a, req1_b, req1_m)}
                                           : {1'b0, model(req0_a, req0_b, req0_m)});
                if (g_id.size() == 4) drop = 1;
            end
        end
        rsp0_ready = 0; rsp1_ready = 0;
        total++;
        if (g_id.size() != 4 || g_id[0] != 0 || g_id[1] != 1 || g_id[2] != 0 || g_id[3] != 1) begin
            bad++; $display("FAIL cont_order: got %p, want 0 1 0 1", g_id);
        end
        total++;
        if (g_cyc.size() != 4 || g_cyc[1] - g_cyc[0] != 3 || g_cyc[2] - g_cyc[1] != 3 ||
            g_cyc[3] - g_cyc[2] != 3) begin
            bad++; $display("FAIL cont_spacing: got cycles %p, want 3 apart", g_cyc);
        end
        total++;
        if (both_rdy != 0 || both_rsp != 0) begin
            bad++; $display("FAIL cont_exclusive: both_ready=%0d both_rsp=%0d, want 0 0", both_rdy, both_rsp);
        end
        total++;
        if (n_rsp != 4 || bad_rsp != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL cont_results: got n=%0d wrong=%0d left=%0d, want 4 0 0", n_rsp, bad_rsp, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok; logic [9:0] e; logic [7:0] w0; logic ov0; int held_bad, waitc;
        do_reset();
        send_req(0, 8'h70, 8'h20, 1'b0, ok);
        waitc = 0;
        while (rsp0_valid !== 1'b1 && waitc < 20) begin @(negedge clk); #1; waitc++; end
        e = exp_q.pop_front();
        w0 = rsp_w; ov0 = rsp_ov;
        total++;
        if (!ok || rsp0_valid !== 1'b1 || {ov0, w0} !== e[8:0]) begin
            bad++; $display("FAIL bp_first: got valid=%b w=%h ov=%b, want 1 %h %b", rsp0_valid, w0, ov0, e[7:0], e[8]);
        end
        req1_valid = 1; req1_a = 8'h11; req1_b = 8'h22; req1_m = 0;
        held_bad = 0;
        for (int i = 0; i < 5; i++) begin
            rsp1_ready = i[0];
            @(negedge clk); #1;
            if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_w !== w0 || rsp_ov !== ov0 ||
                busy !== 1'b1 || req1_ready !== 1'b0 || rsp_w !== e[7:0])
                held_bad++;
        end
        total++;
        if (held_bad != 0) begin
            bad++; $display("FAIL bp_hold: got %0d unstable cycles, want 0", held_bad);
        end
        rsp1_ready = 0;
        rsp0_ready = 1; req1_valid = 0;
        @(posedge clk);
        @(negedge clk); #1;
        rsp0_ready = 0;
        total++;
        if (dbg_state !== 2'd0 || busy !== 1'b0 || rsp0_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release: got st=%0d busy=%b v=%b, want 0 0 0", dbg_state, busy, rsp0_valid);
        end
        exp_cnt = cnt_step(exp_cnt, e[8]);
    endtask

    task automatic test_reset_mid();
        bit ok, rok; logic [7:0] w; logic ov; int lat, stray; logic [9:0] e; logic [13:0] obs;
        do_reset();
        send_req(0, 8'd100, 8'd28, 1'b0, ok);
        wait_rsp(0, 1'b0, w, ov, lat, rok);
        e = exp_q.pop_front();
        exp_cnt = cnt_step(exp_cnt, e[8]);
        total++;
        if (ovf_count !== exp_cnt || {ov, w} !== e[8:0]) begin
            bad++; $display("FAIL mid_pre: got cnt=%0d w=%h, want %0d %h", ovf_count, w, exp_cnt, e[7:0]);
        end
        send_req(1, 8'd9, 8'd9, 1'b0, ok);
        #1;
        total++;
        if (dbg_state !== 2'd1) begin
            bad++; $display("FAIL mid_in_exec: got st=%0d want 1", dbg_state);
        end
        rst_n = 0;
        #1;
        obs = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_w, rsp_ov, busy};
        total++;
        if (obs !== 14'd0 || ovf_count !== '0 || dbg_state !== 2'd0) begin
            bad++; $display("FAIL mid_async: got outs=%h cnt=%0d st=%0d, want 0", obs, ovf_count, dbg_state);
        end
        exp_q.delete(); exp_cnt = '0;
        @(negedge clk);
        rst_n = 1;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (rsp0_valid || rsp1_valid || busy) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++; $display("FAIL mid_no_rsp: got %0d stray cycles want 0", stray);
        end
        req0_valid = 1; req1_valid = 1; #1;
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            bad++; $display("FAIL mid_first_grant: got r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        repeat (2) @(negedge clk);
        rsp0_ready = 1; rsp1_ready = 1;
        repeat (2) @(negedge clk);
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic test_saturation();
        logic [17:0] tbl [5] = '{{1'b0, 8'd100, 8'd28, 1'b0}, {1'b1, 8'h80, 8'h01, 1'b1},
                                 {1'b0, 8'd127, 8'd1, 1'b0}, {1'b1, 8'h80, 8'h7F, 1'b1},
                                 {1'b0, 8'h90, 8'h90, 1'b0}};
        bit ok, rok; logic [7:0] w; logic ov; int lat; logic [9:0] e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_req(tbl[i][17], tbl[i][16:9], tbl[i][8:1], tbl[i][0], ok);
            wait_rsp(tbl[i][17], 1'b0, w, ov, lat, rok);
            e = exp_q.pop_front();
            exp_cnt = cnt_step(exp_cnt, e[8]);
            total++;
            if (!ok || !rok || lat !== 2 || {ov, w} !== e[8:0] || ovf_count !== exp_cnt) begin
                bad++;
                $display("FAIL sat_op[%0d]: got w=%h ov=%b lat=%0d cnt=%0d, want w=%h ov=%b lat=2 cnt=%0d",
                         i, w, ov, lat, ovf_count, e[7:0], e[8], exp_cnt);
            end
        end
        total++;
        if (ovf_count !== 2'd3) begin
            bad++; $display("FAIL sat_value: got %0d want 3", ovf_count);
        end
        send_req(1, 8'h7F, 8'hFF, 1'b1, ok);
        wait_rsp(1, 1'b1, w, ov, lat, rok);
        e = exp_q.pop_front();
        exp_cnt = '0;
        total++;
        if ({ov, w} !== e[8:0] || e[8] !== 1'b1 || ovf_count !== exp_cnt) begin
            bad++; $display("FAIL sat_clr_priority: got w=%h ov=%b cnt=%0d, want %h 1 0", w, ov, ovf_count, e[7:0]);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        test_reset();
        test_add();
        test_overflow();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one 8-bit two's-complement add/subtract datapath (w = a + b when m=0, w = a − b when m=1, signed-overflow flag) between two requesters.
- Requests use a valid/ready handshake. Grants are round-robin, with one operation in flight at a time.
- Results return on a shared data bus, qualified by a per-requester response valid/ready handshake.
- Also keeps a saturating count of signed-overflow results for status readout.

Parameters:
- OVF_CNT_W, 8, width of the overflow event counter (saturates at 2^OVF_CNT_W − 1).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  8  requester 0 operand a
- req0_b  in  8  requester 0 operand b
- req0_m  in  1  requester 0 mode: 0 add, 1 subtract
- req1_valid, req1_ready, req1_a, req1_b, req1_m  same as above, for requester 1
- rsp0_valid  out  1  result for requester 0 on rsp_w/rsp_ov
- rsp0_ready  in  1  requester 0 takes result
- rsp1_valid  out  1  result for requester 1
- rsp1_ready  in  1  requester 1 takes result
- rsp_w  out  8  result value
- rsp_ov  out  1  signed overflow of result (carry into bit7 XOR carry out of bit7)
- busy  out  1  high in any state other than IDLE
- ovf_clr  in  1  synchronous clear of ovf_count
- ovf_count  out  OVF_CNT_W  number of overflowing results delivered

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values:
  - All outputs 0: req*_ready, rsp*_valid, rsp_w, rsp_ov, busy, ovf_count.
  - Operand registers 0.
  - last_grant = 1, so requester 0 wins the first contention.
- IDLE:
  - If exactly one reqN_valid is high, grant N.
  - If both are high, grant the requester != last_grant.
  - reqN_ready is driven combinationally high for the granted requester only, in IDLE only.
  - On the grant edge: latch a, b, m and grant id into operand registers, then go to EXEC.
  - With no valid, stay in IDLE.
- EXEC:
  - The shared datapath evaluates the latched operands.
  - rsp_w and rsp_ov are registered, last_grant is set to the granted id, and the FSM goes to RESP.
  - This state lasts exactly one cycle.
- RESP:
  - rspN_valid is high for the granted id only.
  - rsp_w and rsp_ov are stable until the handshake completes.
  - When rspN_valid && rspN_ready: go to IDLE. In the same edge, if rsp_ov=1 and the counter is not saturated, ovf_count increments.
  - A rspN_ready on the non-granted port is ignored.
- Latency and throughput:
  - Request handshake edge to rsp valid: 2 cycles.
  - Minimum spacing between accepts: 3 cycles, since the next grant can occur in the first cycle after return to IDLE.
- Request valid rules:
  - reqN_valid may drop without being granted; no state effect.
  - Once granted, the operands are owned by the arbiter; input changes are ignored.
- Arithmetic:
  - Modular 8-bit arithmetic; carry-out is discarded.
  - Subtract is implemented as a + ~b + 1, with m as the carry-in.
  - ov = c7 ^ c6.
- ovf_count:
  - Saturates at all-ones.
  - ovf_clr has priority over an increment in the same cycle: the result is 0.
  - ovf_clr is legal in any state.
- Reset mid-operation (asserting rst_n low in EXEC or RESP):
  - Immediately clears state to IDLE and deasserts rsp*_valid.
  - The in-flight result is discarded, and ovf_count is cleared.

Decomposition:
- Shared package holds:
  - FSM state encoding constants ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2
  - The add/subtract mode constants MODE_ADD=0, MODE_SUB=1
  - Data width constant DW=8
- One sub-module: the existing 8-bit add/subtract datapath (combinational, inputs a, b, m; outputs w, overflow). It is instantiated once, driven from the operand registers.

Test Plan:
- Add, no overflow: req0 a=100, b=27, m=0 -> req0_ready in IDLE; rsp0_valid 2 cycles later; rsp_w=127, rsp_ov=0; ovf_count stays 0.
- Add with overflow, then subtract with overflow:
  - a=100, b=28, m=0 -> rsp_w=0x80, rsp_ov=1, ovf_count=1 after the handshake.
  - a=0x80, b=0x01, m=1 -> rsp_w=0x7F, rsp_ov=1, ovf_count=2.
- Contention after reset: both valid every cycle, req0 a=1,b=1 and req1 a=5,b=3 with m=1 -> grants alternate 0,1,0,1.
  - Results 2 on rsp0 and 2 on rsp1.
  - Never both rsp valid; accepts exactly 3 cycles apart with rsp ready tied high.
- Backpressure: hold rsp0_ready low for 5 cycles in RESP -> rsp0_valid, rsp_w and rsp_ov held constant, busy=1, req1_ready stays 0 despite req1_valid.
  - Releasing rsp0_ready completes the handshake and returns to IDLE.
- Reset mid-operation: assert rst_n low during EXEC -> all outputs 0 asynchronously, FSM in IDLE, no rsp valid after release.
  - The next contention grants requester 0 first.
- Counter saturation with OVF_CNT_W=2: 5 overflowing results -> ovf_count=3.
  - ovf_clr pulsed on the same edge as an overflowing handshake -> ovf_count=0.
